// File: rtl/matrix_stream_loader_if.sv
// Stream and flattened-operand bundle between a matrix element source and the loader.
// The master drives elements and start requests; the slave presents the assembled operands.
interface matrix_stream_loader_if #(
  parameter int unsigned MAX_SIZE   = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned FlatW = MAX_SIZE * MAX_SIZE * DATA_WIDTH;

  logic                  start;
  logic [31:0]           matrix_size;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [FlatW-1:0]      A_out;
  logic [FlatW-1:0]      B_out;
  logic [31:0]           size_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, matrix_size, in_data, in_valid,
    input  in_ready, A_out, B_out, size_out, busy, done, err
  );

  modport slave (
    input  start, matrix_size, in_data, in_valid,
    output in_ready, A_out, B_out, size_out, busy, done, err
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Sequential front-end for the flattened matrix multiplier: collects row-major A then B
// from a valid/ready stream into MAX_SIZE-strided flat buses and pulses done when complete.
module matrix_stream_loader #(
  parameter int unsigned MAX_SIZE   = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  matrix_stream_loader_if.slave bus
);
  localparam int unsigned FlatW = MAX_SIZE * MAX_SIZE * DATA_WIDTH;
  localparam int unsigned CntW  = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam int unsigned OffW  = $clog2(FlatW);

  typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   row_q, row_d, col_q, col_d;
  logic [FlatW-1:0]  a_q, a_d, b_q, b_d;
  logic [31:0]       size_q, size_d;
  logic              err_q, err_d;

  logic              loading, beat, size_ok, last_col, last_row;
  logic [31:0]       idx;
  logic [OffW-1:0]   off;

  assign loading  = (state_q == StLoadA) || (state_q == StLoadB);
  assign beat     = loading && bus.in_valid;
  assign size_ok  = (bus.matrix_size != 32'd0) && (bus.matrix_size <= 32'(MAX_SIZE));
  assign last_col = (32'(col_q) == size_q - 32'd1);
  assign last_row = (32'(row_q) == size_q - 32'd1);
  // Row stride is always MAX_SIZE so the multiplier sees a fixed layout for every n.
  assign idx      = 32'(row_q) * MAX_SIZE + 32'(col_q);
  assign off      = OffW'(idx * DATA_WIDTH);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    a_d     = a_q;
    b_d     = b_q;
    size_d  = size_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (size_ok) begin
            size_d  = bus.matrix_size;
            a_d     = '0;
            b_d     = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = StLoadA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoadA, StLoadB: begin
        if (beat) begin
          if (state_q == StLoadA) a_d[off +: DATA_WIDTH] = bus.in_data;
          else                    b_d[off +: DATA_WIDTH] = bus.in_data;
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = (state_q == StLoadA) ? StLoadB : StDone;
            end else begin
              row_d = row_q + CntW'(1);
            end
          end else begin
            col_d = col_q + CntW'(1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      a_q     <= a_d;
      b_q     <= b_d;
      size_q  <= size_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready = loading;
  assign bus.busy     = loading;
  assign bus.done     = (state_q == StDone);
  assign bus.err      = err_q;
  assign bus.A_out    = a_q;
  assign bus.B_out    = b_q;
  assign bus.size_out = size_q;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: table of load scenarios checked against a stream-to-matrix
// model, plus hand-written reset sequences.
module tb_matrix_stream_loader;
  localparam int unsigned MS = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned FW = MS * MS * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matrix_stream_loader_if #(.MAX_SIZE(MS), .DATA_WIDTH(DW)) bus ();

  matrix_stream_loader #(.MAX_SIZE(MS), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int n;          // requested dimension (ignored when rand_n)
    int vmode;      // 0 continuous, 1 alternate cycles, 2 random
    bit mid_start;  // toggle start/matrix_size randomly during the load
    int vals_mode;  // 0 random, 1 values 1,2,3..., 2 values 9,7
    int abort_after;// beats before an asynchronous reset, -1 for none
    bit rand_n;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_a = '0;
  logic [FW-1:0] exp_b = '0;
  int exp_size = 0;
  int stream[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_mat(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int e = 0; e < int'(MS * MS); e++) begin
        if (act[e*DW +: DW] !== exp[e*DW +: DW]) begin
          $display("FAIL %s: element %0d got %0h expected %0h", name, e,
                   act[e*DW +: DW], exp[e*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Element k of a matrix stream lands at row k/n, column k%n, stride MS.
  function automatic logic [FW-1:0] model_mat(input int n, input int base);
    logic [FW-1:0] m = '0;
    for (int k = 0; k < n * n; k++) m[((k / n) * MS + (k % n)) * DW +: DW] = stream[base + k];
    return m;
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_flags"}, {60'd0, bus.in_ready, bus.busy, bus.done, bus.err}, 64'd0);
    chk({tag, "_size"}, 64'(bus.size_out), 64'd0);
    chk_mat({tag, "_A"}, bus.A_out, '0);
    chk_mat({tag, "_B"}, bus.B_out, '0);
  endtask

  // Called 1 time unit after an edge; asserts rst mid-cycle and checks it acts at once.
  task automatic async_reset(input string tag);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero_outputs(tag);
    exp_a = '0;
    exp_b = '0;
    exp_size = 0;
    #2 rst = 1'b0;
    step();
  endtask

  task automatic run_bad(input int n);
    bus.start = 1'b1;
    bus.matrix_size = n;
    step();
    bus.start = 1'b0;
    chk("err_pulse", {60'd0, bus.in_ready, bus.busy, bus.done, bus.err}, 64'b0001);
    step();
    chk("err_cleared_idle", {60'd0, bus.in_ready, bus.busy, bus.done, bus.err}, 64'd0);
    chk_mat("err_A_kept", bus.A_out, exp_a);
    chk_mat("err_B_kept", bus.B_out, exp_b);
    chk("err_size_kept", 64'(bus.size_out), 64'(exp_size));
  endtask

  task automatic run_load(input int n, input int vmode, input bit mid_start, input int vals_mode,
                          input int abort_after);
    int total = 2 * n * n;
    int budget = 4 * total + 20;
    int k = 0;
    int cyc = 0;
    bit v;
    stream.delete();
    for (int i = 0; i < total; i++) begin
      if (vals_mode == 1) stream.push_back(i + 1);
      else if (vals_mode == 2) stream.push_back((i == 0) ? 9 : 7);
      else stream.push_back(int'($urandom));
    end
    bus.start = 1'b1;
    bus.matrix_size = n;
    step();
    bus.start = 1'b0;
    exp_size = n;
    chk_mat("clear_A", bus.A_out, '0);
    chk_mat("clear_B", bus.B_out, '0);
    chk("size_latched", 64'(bus.size_out), 64'(n));
    while (k < total && cyc < budget) begin
      if (k == abort_after) begin
        async_reset("abort");
        return;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? stream[k] : $urandom;
      if (mid_start) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.matrix_size = $urandom_range(0, 15);
      end
      chk("load_flags", {60'd0, bus.in_ready, bus.busy, bus.done, bus.err}, 64'b1100);
      step();
      if (v) k++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    if (k < total) chk("load_budget", 64'(k), 64'(total));
    chk("done_flags", {60'd0, bus.in_ready, bus.busy, bus.done, bus.err}, 64'b0010);
    step();
    chk("after_done_flags", {60'd0, bus.in_ready, bus.busy, bus.done, bus.err}, 64'd0);
    exp_a = model_mat(n, 0);
    exp_b = model_mat(n, n * n);
    chk_mat("A_contents", bus.A_out, exp_a);
    chk_mat("B_contents", bus.B_out, exp_b);
    chk("size_after_load", 64'(bus.size_out), 64'(exp_size));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{n: 2,  vmode: 0, mid_start: 0, vals_mode: 1, abort_after: -1, rand_n: 0};
    vecs[1] = '{n: 3,  vmode: 1, mid_start: 1, vals_mode: 0, abort_after: -1, rand_n: 0};
    vecs[2] = '{n: 0,  vmode: 0, mid_start: 0, vals_mode: 0, abort_after: -1, rand_n: 0};
    vecs[3] = '{n: 11, vmode: 0, mid_start: 0, vals_mode: 0, abort_after: -1, rand_n: 0};
    vecs[4] = '{n: 10, vmode: 0, mid_start: 0, vals_mode: 1, abort_after: -1, rand_n: 0};
    vecs[5] = '{n: 2,  vmode: 0, mid_start: 0, vals_mode: 0, abort_after: 6,  rand_n: 0};
    vecs[6] = '{n: 1,  vmode: 0, mid_start: 0, vals_mode: 2, abort_after: -1, rand_n: 0};
    vecs[7] = '{n: 0,  vmode: 2, mid_start: 1, vals_mode: 0, abort_after: -1, rand_n: 1};
    vecs[8] = '{n: 0,  vmode: 2, mid_start: 0, vals_mode: 0, abort_after: -1, rand_n: 1};
    vecs[9] = '{n: 0,  vmode: 2, mid_start: 1, vals_mode: 0, abort_after: -1, rand_n: 1};

    bus.start = 1'b0;
    bus.matrix_size = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    step();
    step();
    async_reset("reset");

    for (int i = 0; i < 10; i++) begin
      int n = vecs[i].rand_n ? int'($urandom_range(1, MS)) : vecs[i].n;
      if (n < 1 || n > int'(MS)) run_bad(n);
      else run_load(n, vecs[i].vmode, vecs[i].mid_start, vecs[i].vals_mode, vecs[i].abort_after);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Sequential front-end for the flattened parallel matrix multiplier. It accepts matrix elements one at a time over a valid/ready stream: row-major A first, then row-major B. It assembles them into the flattened A/B buses that the multiplier consumes, and presents a registered `size_out` and a one-cycle `done` once both operands are complete.

## Interface

Parameters:
- `MAX_SIZE`, default 10: maximum matrix dimension; must match the multiplier.
- `DATA_WIDTH`, default 32: width of each element.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a load; sampled only in IDLE.
- `matrix_size`  in  32  dimension n of the next load; sampled with `start`.
- `in_data`  in  DATA_WIDTH  element value.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts an element this cycle.
- `A_out`  out  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened A; element (i,j) at bits `[(i*MAX_SIZE+j)*DATA_WIDTH +: DATA_WIDTH]`.
- `B_out`  out  same  flattened B; same layout.
- `size_out`  out  32  n latched at the accepted start.
- `busy`  out  1  high in LOAD_A and LOAD_B.
- `done`  out  1  one-cycle pulse when A and B are complete.
- `err`  out  1  one-cycle pulse when a start is rejected.

## Operation

- States: IDLE, LOAD_A, LOAD_B, DONE.
- IDLE, `start`=1, 1 ≤ `matrix_size` ≤ MAX_SIZE:
  - latch n into `size_out`;
  - clear all of `A_out` and `B_out` to 0;
  - row=col=0;
  - go to LOAD_A.
- IDLE, `start`=1, `matrix_size` = 0 or > MAX_SIZE:
  - pulse `err` next cycle;
  - stay in IDLE;
  - `A_out`, `B_out` and `size_out` are unchanged.
- `in_ready` = 1 exactly in LOAD_A and LOAD_B. A beat is `in_valid & in_ready` at a rising edge.
- Each beat writes `in_data` to element (row,col) of A (LOAD_A) or B (LOAD_B), then advances the counters:
  - col = n−1: col → 0, row → row+1;
  - otherwise col → col+1.
- Beat at (n−1,n−1):
  - in LOAD_A: row=col=0, go to LOAD_B;
  - in LOAD_B: go to DONE.
- DONE: `done`=1 for this one cycle, then IDLE unconditionally.
- Elements outside the n×n region remain 0, so the multiplier's masking sees clean zeros.
- `start` is ignored outside IDLE, including in DONE.
- `in_valid` while not ready is ignored. No data is buffered.
- `A_out`, `B_out` and `size_out` hold their values in IDLE until the next accepted start.
- row/col counters are $clog2(MAX_SIZE) bits wide. Index arithmetic uses MAX_SIZE as the row stride, never n.

## Timing

- Reset values: state IDLE; `A_out`=0, `B_out`=0, `size_out`=0; `in_ready`=0, `busy`=0, `done`=0, `err`=0; counters 0.
- `rst` asserted mid-load aborts immediately. All outputs return to reset values and partially loaded data is discarded.
- All outputs are registered, or decoded only from the state register (`in_ready`, `busy`).
- Accepted start at edge T:
  - `busy` and `in_ready` are high from T+1;
  - the clears are visible at T+1.
- With `in_valid` held high, the last B beat lands at edge T+2n². `done` is high during the cycle after that edge, and `in_ready` is low in that same cycle.
- Minimum start-to-start spacing: 2n²+2 cycles.
- Bubbles in `in_valid` stretch the load cycle-for-cycle. Counters advance only on beats.
- `err` pulses in the cycle after the rejected start.

## Test plan

- Reset check: assert `rst` asynchronously, mid-cycle. Required: all outputs 0 immediately; `in_ready`=0.
- n=2, continuous stream 1,2,3,4,5,6,7,8. Required:
  - A(0,0)=1, A(0,1)=2, A(1,0)=3, A(1,1)=4, i.e. flat indices 0, 1, 10, 11;
  - B holds 5..8 at the same indices;
  - all other elements 0;
  - `done` high exactly one cycle, 8 edges after the first `busy` cycle;
  - `size_out`=2.
- n=3 with `in_valid` toggling every other cycle. Required: 18 beats are accepted, and A/B contents match the values sent. Include `start` pulsed mid-load: required no effect.
- Invalid size: start with n=0, then n=MAX_SIZE+1. Required: `err` pulses each time; state stays IDLE; previous `A_out`/`B_out`/`size_out` unchanged.
- n=MAX_SIZE with values k=1..200. Required:
  - A element k−1 = k, B element k−1 = k+100;
  - counters wrap correctly;
  - `done` arrives after 200 beats.
- Reset during LOAD_B of an n=2 load (after 6 beats). Required: all outputs 0. A subsequent n=1 load with values 9,7 gives A(0,0)=9, B(0,0)=7, and every other element 0.
